// File: rtl/mem_reader_if.sv
// mem_reader_if: memory port-B bus plus the output word stream of mem_reader.
//   master (mem_reader): drives addr_b/we_b/data_b and out_valid/out_data;
//                        receives q_b and out_ready.
//   slave  (memory + downstream consumer): the mirror image.
interface mem_reader_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 6
);
    logic [ADDR_W-1:0] addr_b;
    logic              we_b;
    logic [DATA_W-1:0] data_b;
    logic [DATA_W-1:0] q_b;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;

    modport master (
        output addr_b, we_b, data_b, out_valid, out_data,
        input  q_b, out_ready
    );

    modport slave (
        input  addr_b, we_b, data_b, out_valid, out_data,
        output q_b, out_ready
    );
endinterface

// File: rtl/mem_reader.sv
// mem_reader: burst read engine for a synchronous-read memory port B.
// Sweeps length words from base_addr (wrapping mod 2^ADDR_W) and streams
// them in address order through a FIFO_D-deep buffer on a valid/ready port.
// Ports:
//   clk, reset_L          clock, asynchronous active-low reset
//   start                 burst request (sampled only in IDLE)
//   base_addr, length     burst first address and word count (0..2^ADDR_W)
//   busy, done            burst in progress / one-cycle completion pulse
//   bus (master)          addr_b/we_b/data_b/q_b memory port,
//                         out_valid/out_data/out_ready stream
module mem_reader #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned FIFO_D = 4
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    mem_reader_if.master      bus
);

    localparam int unsigned LEN_W = ADDR_W + 1;
    localparam int unsigned PTR_W = $clog2(FIFO_D);
    localparam int unsigned CNT_W = $clog2(FIFO_D + 1);
    localparam int unsigned OCC_W = CNT_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  rem_issue_q;
    logic [LEN_W-1:0]  rem_deliver_q;
    logic [1:0]        tag_q;          // [0]: address on addr_b, [1]: data on q_b
    logic [DATA_W-1:0] fifo_q [FIFO_D];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              busy_q, done_q;

    logic              first_issue, issue, push, pop;
    logic [OCC_W-1:0]  occ;

    // Buffered words plus reads still in the memory pipeline; issue only while
    // every outstanding read is guaranteed a FIFO slot.
    assign occ = OCC_W'(count_q) + OCC_W'(tag_q[0]) + OCC_W'(tag_q[1]);

    // State register
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and per-cycle issue/push/pop decisions
    always_comb begin
        state_d     = state_q;
        first_issue = 1'b0;
        issue       = 1'b0;
        pop         = 1'b0;
        push        = tag_q[1];
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (length != '0) begin
                        state_d     = RUN;
                        first_issue = 1'b1;
                    end else begin
                        state_d = FIN;
                    end
                end
            end
            RUN: begin
                issue = (rem_issue_q != '0) && (occ < OCC_W'(FIFO_D));
                pop   = (count_q != '0) && bus.out_ready;
                if (pop && (rem_deliver_q == LEN_W'(1))) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Address generation, counters, issue tags and output FIFO
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            addr_q        <= '0;
            rem_issue_q   <= '0;
            rem_deliver_q <= '0;
            tag_q         <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            for (int i = 0; i < int'(FIFO_D); i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            busy_q <= (state_d == RUN);
            done_q <= (state_d == FIN);
            tag_q  <= {tag_q[0], first_issue | issue};

            // The start cycle issues the first read at base_addr directly.
            if (first_issue) begin
                addr_q        <= base_addr;
                rem_issue_q   <= length - LEN_W'(1);
                rem_deliver_q <= length;
            end else begin
                if (issue) begin
                    addr_q      <= addr_q + ADDR_W'(1);
                    rem_issue_q <= rem_issue_q - LEN_W'(1);
                end
                if (pop) begin
                    rem_deliver_q <= rem_deliver_q - LEN_W'(1);
                end
            end

            if (push) begin
                fifo_q[wr_ptr_q] <= bus.q_b;
                wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign bus.addr_b    = addr_q;
    assign bus.we_b      = 1'b0;
    assign bus.data_b    = '0;
    assign bus.out_valid = (count_q != '0);
    assign bus.out_data  = fifo_q[rd_ptr_q];
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_mem_reader.sv
// tb_mem_reader: directed, table-driven bench for mem_reader with a
// synchronous-read 64 x 8 memory model on port B.
module tb_mem_reader;

    logic       clk = 1'b0;
    logic       reset_L;
    logic       start;
    logic [5:0] base_addr;
    logic [6:0] length;
    logic       busy, done;
    logic       out_ready;
    logic [7:0] q_b;
    logic [7:0] mem [64];

    int checks = 0;
    int errors = 0;

    mem_reader_if #(.DATA_W(8), .ADDR_W(6)) bus ();

    assign bus.q_b       = q_b;
    assign bus.out_ready = out_ready;

    mem_reader #(.DATA_W(8), .ADDR_W(6), .FIFO_D(4)) dut (
        .clk       (clk),
        .reset_L   (reset_L),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    // Synchronous-read memory: address in cycle n, data in cycle n+1.
    always @(posedge clk) q_b <= mem[bus.addr_b];

    typedef struct {
        logic [5:0] base;
        logic [6:0] len;
        int         stall_lo;   // out_ready low for cycles stall_lo..stall_hi
        int         stall_hi;
        bit         mid_start;  // extra start pulse in cycle 2
        int         exp_done;   // cycle in which done must pulse
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One burst: start in cycle 0, then observe cycles 1..exp_done+1.
    task automatic run_vec(input vec_t v);
        int         idx = 0;
        int         nfill;
        bit         stalled;
        logic [5:0] a;
        nfill   = (int'(v.len) < 4) ? int'(v.len) : 4;
        stalled = (v.stall_hi >= v.stall_lo);
        @(negedge clk);
        start     = 1'b1;
        base_addr = v.base;
        length    = v.len;
        out_ready = 1'b1;
        for (int cyc = 1; cyc <= v.exp_done + 1; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                start     = 1'b0;
                base_addr = '0;
                length    = '0;
            end
            if (v.mid_start && cyc == 2) begin
                start     = 1'b1;
                base_addr = 6'd40;
                length    = 7'd5;
            end else if (v.mid_start && cyc == 3) begin
                start = 1'b0;
            end
            out_ready = !(cyc >= v.stall_lo && cyc <= v.stall_hi);

            chk("busy", 32'(busy), 32'((v.len != 0) && (cyc < v.exp_done)));
            chk("done", 32'(done), 32'(cyc == v.exp_done));
            chk("we_b_data_b", {23'd0, bus.we_b, bus.data_b}, 32'd0);

            if (!stalled && cyc <= int'(v.len)) begin
                a = v.base + 6'(cyc - 1);
                chk("addr_seq", 32'(bus.addr_b), 32'(a));
            end
            if (cyc >= v.stall_lo && cyc <= v.stall_hi) begin
                chk("stall_valid", 32'(bus.out_valid), 32'd1);
                chk("stall_data", 32'(bus.out_data), 32'(mem[v.base]));
                if (cyc == v.stall_hi) begin
                    a = v.base + 6'(nfill - 1);
                    chk("stall_issue_limit", 32'(bus.addr_b), 32'(a));
                end
            end

            if (bus.out_valid && out_ready) begin
                if (idx < int'(v.len)) begin
                    a = v.base + 6'(idx);
                    chk("word_data", 32'(bus.out_data), 32'(mem[a]));
                    if (!stalled) chk("word_cycle", 32'(cyc), 32'(3 + idx));
                end else begin
                    chk("extra_word", 32'(idx + 1), 32'(v.len));
                end
                idx++;
            end
        end
        chk("word_count", 32'(idx), 32'(v.len));
        out_ready = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 8'(i * 7 + 3);
        mem[5] = 8'hA0;
        mem[6] = 8'hA1;
        mem[7] = 8'hA2;
        mem[8] = 8'hA3;

        //        base   len    stall_lo stall_hi mid done
        vecs[0] = '{6'd5,  7'd4,  0, -1, 1'b0,  7};   // basic burst
        vecs[1] = '{6'd62, 7'd4,  0, -1, 1'b0,  7};   // wrap 63 -> 0
        vecs[2] = '{6'd0,  7'd64, 0, -1, 1'b0, 67};   // full depth
        vecs[3] = '{6'd5,  7'd4,  3,  9, 1'b0, 14};   // backpressure
        vecs[4] = '{6'd10, 7'd10, 3,  9, 1'b0, 20};   // backpressure, issue stall
        vecs[5] = '{6'd20, 7'd0,  0, -1, 1'b0,  1};   // length zero
        vecs[6] = '{6'd30, 7'd3,  0, -1, 1'b1,  6};   // start ignored in RUN
        vecs[7] = '{6'd5,  7'd2,  0, -1, 1'b0,  5};   // burst after mid-burst reset

        // Reset held with random inputs; asserted asynchronously at time 0.
        reset_L   = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        length    = '0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start     = 1'($urandom);
            base_addr = 6'($urandom);
            length    = 7'($urandom_range(1, 64));
            out_ready = 1'($urandom);
        end
        #1;
        chk("rst_addr_b", 32'(bus.addr_b), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data", 32'(bus.out_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_we_b", 32'(bus.we_b), 32'd0);
        @(negedge clk);
        start     = 1'b0;
        out_ready = 1'b1;
        reset_L   = 1'b1;

        for (int v = 0; v < 7; v++) run_vec(vecs[v]);

        // Mid-burst reset: 4-word burst, reset after two handshakes.
        @(negedge clk);
        start     = 1'b1;
        base_addr = 6'd5;
        length    = 7'd4;
        begin
            int hs = 0;
            for (int cyc = 1; cyc <= 5 && hs < 2; cyc++) begin
                @(negedge clk);
                if (cyc == 1) start = 1'b0;
                if (bus.out_valid && out_ready) hs++;
            end
            chk("midrst_handshakes", 32'(hs), 32'd2);
        end
        #2 reset_L = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_addr_b", 32'(bus.addr_b), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("midrst_no_done", {30'd0, done, bus.out_valid}, 32'd0);
        end
        reset_L = 1'b1;
        run_vec(vecs[7]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
